// File: rtl/game_tick_ctrl_if.sv
// Control pulses into and tick/status out of the game tick controller.
// master drives the pulses (game FSM side), slave is the controller itself.
interface game_tick_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             pause;
    logic             step;
    logic             level_up;
    logic             game_over;
    logic             tick;
    logic [2:0]       level;
    logic [1:0]       state;
    logic [CNT_W-1:0] tick_count;

    modport master (
        output start, pause, step, level_up, game_over,
        input  tick, level, state, tick_count
    );

    modport slave (
        input  start, pause, step, level_up, game_over,
        output tick, level, state, tick_count
    );
endinterface

// File: rtl/game_tick_ctrl.sv
// Game phase FSM plus prescaled tick divider; every output registered, 1-cycle latency.
// No backpressure: inputs are single-cycle pulses and tick is a fire-and-forget enable.
module game_tick_ctrl #(
    parameter int BASE_DIV = 1000000,
    parameter int CNT_W    = 16
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    game_tick_ctrl_if.slave  gif
);
    localparam int PRE_W = $clog2(BASE_DIV);
    typedef logic [PRE_W-1:0] pre_t;
    localparam pre_t PRE_MAX = pre_t'(BASE_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        OVER   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       level_q, level_d;
    logic [2:0]       sub_q,   sub_d;
    pre_t             pre_q,   pre_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             tick_q,  tick_d;

    logic in_game;
    logic restart;

    assign in_game = (state_q == RUN) || (state_q == PAUSED);
    assign restart = ((state_q == IDLE) || (state_q == OVER)) && gif.start;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            level_q <= 3'd0;
            sub_q   <= 3'd7;
            pre_q   <= PRE_MAX;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            sub_q   <= sub_d;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, OVER: if (gif.start) state_d = RUN;
            RUN: begin
                if (gif.game_over)  state_d = OVER;
                else if (gif.pause) state_d = PAUSED;
            end
            PAUSED: begin
                if (gif.game_over)  state_d = OVER;
                else if (gif.pause) state_d = RUN;
            end
        endcase
    end

    // Counters keep running on the edge that pauses; they freeze from the next cycle.
    always_comb begin
        level_d = level_q;
        sub_d   = sub_q;
        pre_d   = pre_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        if (restart) begin
            level_d = 3'd0;
            sub_d   = 3'd7;
            pre_d   = PRE_MAX;
            cnt_d   = '0;
        end else if (in_game && !gif.game_over) begin
            if (gif.level_up && !gif.start && (level_q != 3'd7)) begin
                level_d = level_q + 3'd1;
            end
            if (state_q == RUN) begin
                if (pre_q != '0) begin
                    pre_d = pre_q - pre_t'(1);
                end else begin
                    pre_d = PRE_MAX;
                    if (sub_q == 3'd0) begin
                        tick_d = 1'b1;
                        cnt_d  = cnt_q + CNT_W'(1);
                        sub_d  = 3'd7 - level_q;
                    end else begin
                        sub_d = sub_q - 3'd1;
                    end
                end
            end else if (gif.step && !gif.pause) begin
                tick_d = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
            end
        end
    end

    assign gif.tick       = tick_q;
    assign gif.level      = level_q;
    assign gif.state      = state_q;
    assign gif.tick_count = cnt_q;
endmodule

// File: tb/tb_game_tick_ctrl.sv
// Bench for game_tick_ctrl at BASE_DIV=4, CNT_W=4: pulse table plus tick-time scoreboard.
module tb_game_tick_ctrl;
    localparam int BASE_DIV = 4;
    localparam int CNT_W    = 4;

    localparam logic [4:0] P_NO = 5'b00000;
    localparam logic [4:0] P_GO = 5'b10000;
    localparam logic [4:0] P_ST = 5'b01000;
    localparam logic [4:0] P_PA = 5'b00100;
    localparam logic [4:0] P_SP = 5'b00010;
    localparam logic [4:0] P_LU = 5'b00001;

    logic CLOCK_50 = 1'b0;
    logic resetn   = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    game_tick_ctrl_if #(.CNT_W(CNT_W)) gif ();

    game_tick_ctrl #(.BASE_DIV(BASE_DIV), .CNT_W(CNT_W)) dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .gif      (gif)
    );

    int unsigned cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int unsigned exp_q[$];
    bit   sb_on     = 1'b0;
    logic prev_tick = 1'b0;

    typedef struct packed {
        logic [4:0]       p;
        logic [1:0]       st;
        logic [2:0]       lv;
        logic             tk;
        logic [CNT_W-1:0] cnt;
    } vec_t;

    vec_t tbl[23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    endtask

    task automatic pulse(input logic [4:0] p);
        {gif.game_over, gif.start, gif.pause, gif.step, gif.level_up} = p;
        @(posedge CLOCK_50);
        #1;
        {gif.game_over, gif.start, gif.pause, gif.step, gif.level_up} = 5'b0;
    endtask

    task automatic wait_edge(input int unsigned n);
        while (cyc < n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    // Scoreboard: each tick must land on the next expected edge, never two in a row.
    always @(negedge CLOCK_50) begin
        if (sb_on && resetn && gif.tick) begin
            chk("tick_gap", 32'(prev_tick), 0);
            if (exp_q.size() == 0) chk("spurious_tick", 32'(gif.tick), 0);
            else                   chk("tick_edge", cyc, exp_q.pop_front());
        end
        prev_tick <= gif.tick;
    end

    initial begin
        int unsigned e0;
        {gif.game_over, gif.start, gif.pause, gif.step, gif.level_up} = 5'b0;

        tbl[0]  = '{P_NO,        2'd0, 3'd0, 1'b0, 4'd0};
        tbl[1]  = '{P_LU,        2'd0, 3'd0, 1'b0, 4'd0};
        tbl[2]  = '{P_PA,        2'd0, 3'd0, 1'b0, 4'd0};
        tbl[3]  = '{P_SP,        2'd0, 3'd0, 1'b0, 4'd0};
        tbl[4]  = '{P_ST,        2'd1, 3'd0, 1'b0, 4'd0};
        tbl[5]  = '{P_ST,        2'd1, 3'd0, 1'b0, 4'd0};
        tbl[6]  = '{P_LU,        2'd1, 3'd1, 1'b0, 4'd0};
        tbl[7]  = '{P_PA,        2'd2, 3'd1, 1'b0, 4'd0};
        tbl[8]  = '{P_LU,        2'd2, 3'd2, 1'b0, 4'd0};
        tbl[9]  = '{P_SP,        2'd2, 3'd2, 1'b1, 4'd1};
        tbl[10] = '{P_NO,        2'd2, 3'd2, 1'b0, 4'd1};
        tbl[11] = '{P_ST,        2'd2, 3'd2, 1'b0, 4'd1};
        tbl[12] = '{P_PA | P_LU, 2'd1, 3'd3, 1'b0, 4'd1};
        tbl[13] = '{P_SP,        2'd1, 3'd3, 1'b0, 4'd1};
        tbl[14] = '{P_GO | P_ST | P_PA, 2'd3, 3'd3, 1'b0, 4'd1};
        tbl[15] = '{P_LU,        2'd3, 3'd3, 1'b0, 4'd1};
        tbl[16] = '{P_PA | P_SP, 2'd3, 3'd3, 1'b0, 4'd1};
        tbl[17] = '{P_ST | P_LU, 2'd1, 3'd0, 1'b0, 4'd0};
        tbl[18] = '{P_LU,        2'd1, 3'd1, 1'b0, 4'd0};
        tbl[19] = '{P_GO | P_LU, 2'd3, 3'd1, 1'b0, 4'd0};
        tbl[20] = '{P_ST,        2'd1, 3'd0, 1'b0, 4'd0};
        tbl[21] = '{P_PA | P_SP, 2'd2, 3'd0, 1'b0, 4'd0};
        tbl[22] = '{P_PA | P_SP, 2'd1, 3'd0, 1'b0, 4'd0};

        #5;
        chk("rst_state", 32'(gif.state), 0);
        chk("rst_level", 32'(gif.level), 0);
        chk("rst_tick",  32'(gif.tick), 0);
        chk("rst_count", 32'(gif.tick_count), 0);
        repeat (2) @(negedge CLOCK_50);
        resetn = 1'b1;
        @(posedge CLOCK_50);
        #1;

        for (int i = 0; i < 23; i++) begin
            pulse(tbl[i].p);
            chk($sformatf("vec%0d_state", i), 32'(gif.state), 32'(tbl[i].st));
            chk($sformatf("vec%0d_level", i), 32'(gif.level), 32'(tbl[i].lv));
            chk($sformatf("vec%0d_tick", i),  32'(gif.tick),  32'(tbl[i].tk));
            chk($sformatf("vec%0d_count", i), 32'(gif.tick_count), 32'(tbl[i].cnt));
        end

        // Asynchronous reset in the middle of a game, taken while tick is high.
        pulse(P_LU);
        pulse(P_LU);
        for (int i = 0; i < 60 && !gif.tick; i++) begin
            @(posedge CLOCK_50);
            #1;
        end
        chk("tick_before_reset", 32'(gif.tick), 1);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_state", 32'(gif.state), 0);
        chk("async_rst_level", 32'(gif.level), 0);
        chk("async_rst_tick",  32'(gif.tick), 0);
        chk("async_rst_count", 32'(gif.tick_count), 0);
        @(negedge CLOCK_50);
        resetn = 1'b1;
        @(posedge CLOCK_50);
        #1;

        // Base rate at level 0: one tick every 32 edges.
        sb_on = 1'b1;
        pulse(P_ST);
        e0 = cyc;
        exp_q.push_back(e0 + 32);
        exp_q.push_back(e0 + 64);
        exp_q.push_back(e0 + 96);
        wait_edge(e0 + 100);
        chk("base_pending", exp_q.size(), 0);
        chk("base_count", 32'(gif.tick_count), 3);
        chk("base_state", 32'(gif.state), 1);
        pulse(P_GO);

        // Pause, step, resume, then a pause on the very edge a tick completes.
        pulse(P_ST);
        e0 = cyc;
        wait_edge(e0 + 9);
        pulse(P_PA);
        wait_edge(e0 + 30);
        chk("paused_state", 32'(gif.state), 2);
        chk("paused_count", 32'(gif.tick_count), 0);
        exp_q.push_back(e0 + 31);
        pulse(P_SP);
        chk("step_tick", 32'(gif.tick), 1);
        chk("step_count", 32'(gif.tick_count), 1);
        exp_q.push_back(e0 + 54);
        pulse(P_PA);
        wait_edge(e0 + 85);
        chk("resume_count", 32'(gif.tick_count), 2);
        exp_q.push_back(e0 + 86);
        pulse(P_PA);
        chk("pause_on_tick", 32'(gif.tick), 1);
        chk("pause_on_tick_state", 32'(gif.state), 2);
        wait_edge(e0 + 95);
        exp_q.push_back(e0 + 128);
        pulse(P_PA);
        wait_edge(e0 + 130);
        chk("pause_pending", exp_q.size(), 0);
        chk("pause_count", 32'(gif.tick_count), 4);
        pulse(P_GO);

        // Saturating level, period shrinks only at the next reload, then count wraps.
        pulse(P_ST);
        e0 = cyc;
        for (int i = 0; i < 9; i++) pulse(P_LU);
        chk("level_sat", 32'(gif.level), 7);
        for (int k = 0; k <= 16; k++) exp_q.push_back(e0 + 32 + 4 * k);
        wait_edge(e0 + 88);
        chk("count_15", 32'(gif.tick_count), 15);
        wait_edge(e0 + 92);
        chk("wrap_tick", 32'(gif.tick), 1);
        chk("wrap_count", 32'(gif.tick_count), 0);
        wait_edge(e0 + 99);
        chk("level_pending", exp_q.size(), 0);
        pulse(P_GO);
        chk("over_tick", 32'(gif.tick), 0);
        chk("over_state", 32'(gif.state), 3);
        chk("over_level", 32'(gif.level), 7);
        chk("over_count", 32'(gif.tick_count), 1);
        repeat (10) @(posedge CLOCK_50);
        #1;
        chk("over_pending", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/game_tick_ctrl.md
# game_tick_ctrl

Game-speed controller that owns the game's timing resource: a single prescaled tick divider running off CLOCK_50. It sequences game phases (idle, run, paused, over) and scales the tick rate with the current difficulty level. It emits a one-cycle `tick` enable that game logic uses instead of a derived clock. It sits between the top-level input/game FSM and every block that advances game state per tick.

## Interface

- `BASE_DIV`, default 1000000: CLOCK_50 cycles per base tick, ≥2. The default gives 20 ms at 50 MHz.
- `CNT_W`, default 16: width of `tick_count`.
- `CLOCK_50`  in  1  sole clock. All logic is on posedge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse; begins a game from IDLE or OVER.
- `pause`  in  1  single-cycle pulse; toggles RUN↔PAUSED.
- `step`  in  1  single-cycle pulse; in PAUSED, emits exactly one tick.
- `level_up`  in  1  single-cycle pulse; increments difficulty level.
- `game_over`  in  1  single-cycle pulse; ends the game.
- `tick`  out  1  registered one-cycle enable pulse.
- `level`  out  3  current difficulty level, 0..7.
- `state`  out  2  IDLE=0, RUN=1, PAUSED=2, OVER=3.
- `tick_count`  out  CNT_W  ticks emitted since the last start; wraps modulo 2^CNT_W.

## Operation

**Reset.** All of the following take these values asynchronously while `resetn`=0:
- `state`=IDLE
- `level`=0
- `tick`=0
- `tick_count`=0
- `pre_cnt`=BASE_DIV-1
- `sub_cnt`=7

**Counters.**
- `pre_cnt` is the prescaler, width ceil(log2(BASE_DIV)).
- `sub_cnt` is 3 bits.

**RUN, each cycle:**
- If `pre_cnt`≠0, decrement `pre_cnt`.
- If `pre_cnt`=0, reload `pre_cnt` to BASE_DIV-1 (this is a base tick), then:
  - if `sub_cnt`=0: set `tick`<=1, increment `tick_count`, and reload `sub_cnt` with 7-`level`, using `level` as registered this cycle;
  - otherwise: decrement `sub_cnt`.
- Resulting tick period is BASE_DIV×(8-`level`) cycles.

**Entering and leaving states:**
- `start` in IDLE or OVER → RUN. Same edge sets `level`=0, `tick_count`=0, `pre_cnt`=BASE_DIV-1, `sub_cnt`=7.
- `start` in RUN or PAUSED is ignored.
- `pause` in RUN → PAUSED. `pause` in PAUSED → RUN. Ignored elsewhere.

**PAUSED:**
- `pre_cnt` and `sub_cnt` are frozen.
- `step` sets `tick`<=1 and increments `tick_count`. Counters are not disturbed.
- `step` outside PAUSED is ignored.

**Level and game over:**
- `level_up` in RUN or PAUSED increments `level`, saturating at 7. It is ignored in IDLE and OVER.
- A new level takes effect at the next `sub_cnt` reload. The period currently in progress is not shortened.
- `game_over` in RUN or PAUSED → OVER. `tick` is 0 from that edge on. `level` and `tick_count` hold for score display.

**Simultaneous pulses** in one cycle:
- Priority is `game_over` > `start` > `pause` > `step`.
- A lower-priority pulse that loses is dropped, not queued.
- `level_up` is independent: it is applied in the same cycle, except when `game_over` or `start` also fires, in which case it is dropped.
- A `pause` taking RUN→PAUSED on the same edge a base tick would complete: the counter update and tick for that edge still happen, and counting freezes from the next cycle.

**Abnormal inputs and reset:**
- Inputs held high for multiple cycles act as one pulse per cycle. Callers must supply edge-detected pulses.
- Reset mid-game discards all state immediately.

## Timing

- All outputs are registered. No combinational path exists from any input to any output.
- Transitions:
  - `start` sampled at edge E0 → `state`=RUN after E0;
  - first `tick` is high in the cycle after edge E0+BASE_DIV×(8-`level`).
- `tick` is high for exactly one cycle. `tick_count` updates on the same edge `tick` rises.
- `step` sampled at edge E → `tick` high for the cycle after E.
- `state` and `level` change on the edge that samples the pulse, with 1-cycle latency.
- `resetn` deassertion must be synchronous to CLOCK_50 at the top level. This block does not resynchronize it.

## Test plan

All scenarios use BASE_DIV=4.

- **Reset values.** Apply `resetn`=0 mid-RUN → `state`=0, `level`=0, `tick`=0, `tick_count`=0 immediately, with no clock needed.
- **Base rate.** `start` at E0, `level`=0 → `tick` pulses after E32, E64, E96. `tick_count`=3 after E96, and never two consecutive high cycles.
- **Max level.** `level_up` ×7, then `level_up` ×2 more → `level` saturates at 7. After the next reload, `tick` period = 4 cycles.
- **Pause and step.** Pause at E10; hold 20 cycles → no ticks, counters frozen. `step` → exactly one tick and `tick_count`+1. Unpause → next tick lands at E32 plus the paused cycles.
- **Collisions.** `game_over`+`start`+`pause` together in RUN → `state`=OVER, `level` unchanged. `start` while in RUN → ignored.
- **Wrap.** CNT_W=4 at `level`=7 → `tick_count` wraps 15→0 on the 16th tick.
